// File: rtl/decoder_n_scan.sv
// decoder_n_scan: N-bit code register driving a registered one-hot decoder.
// The code is either loaded directly or auto-advanced by a prescaled scan.
// Each edge picks one action, in this priority order: load, then scan
// advance, then hold. A change of Mode restarts the prescaler.
module decoder_n_scan #(
    parameter int N   = 2,   // code width, 1..6
    parameter int DIV = 4    // enabled scan cycles per code advance, >= 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 En,
    input  logic                 Mode,
    input  logic                 Load,
    input  logic [N-1:0]         i,
    output logic [(1<<N)-1:0]    o,
    output logic [N-1:0]         code,
    output logic                 tick
);

    localparam int LINES = 1 << N;
    // With DIV=1 the prescaler never leaves 0, but it still needs one bit
    // so that the register is well formed.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [N-1:0]     code_q, code_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             mode_hist_q;
    logic [LINES-1:0] o_q, o_d;
    logic             tick_q, tick_d;
    logic             mode_change;
    logic             advance;

    assign mode_change = (Mode != mode_hist_q);

    // Next-state for code and prescaler: load wins, then a Mode change
    // (restart), then scan counting. Otherwise everything holds.
    always_comb begin
        code_d  = code_q;
        presc_d = presc_q;
        advance = 1'b0;
        if (Load) begin
            code_d  = i;
            presc_d = '0;
        end else if (mode_change) begin
            presc_d = '0;
        end else if (Mode && En) begin
            if (presc_q == PRESC_LAST) begin
                code_d  = code_q + N'(1);
                presc_d = '0;
                advance = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Decoder: one line per code value. Because the decode uses the value
    // the code register is about to take, o and code change on the same edge.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_dec
        assign o_d[gi] = En & (code_d == N'(gi));
    end

    // The tick register marks the edge that advanced the code.
    assign tick_d = advance;

    // State and output registers. Reset clears them asynchronously, so the
    // scan restarts from a full prescale count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q      <= '0;
            presc_q     <= '0;
            mode_hist_q <= 1'b0;
            o_q         <= '0;
            tick_q      <= 1'b0;
        end else begin
            code_q      <= code_d;
            presc_q     <= presc_d;
            mode_hist_q <= Mode;
            o_q         <= o_d;
            tick_q      <= tick_d;
        end
    end

    assign o    = o_q;
    assign code = code_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_decoder_n_scan.sv
// Testbench for decoder_n_scan (N=2, DIV=4).
// Stimulus pushes hand-computed expectations into a queue. A separate monitor
// pops one entry after each edge and compares it with the outputs.
module tb_decoder_n_scan;

    localparam int N   = 2;
    localparam int DIV = 4;

    logic       clk;
    logic       rst_n;
    logic       En;
    logic       Mode;
    logic       Load;
    logic [1:0] i;
    logic [3:0] o;
    logic [1:0] code;
    logic       tick;

    typedef struct packed {
        logic [3:0] o;
        logic [1:0] code;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    decoder_n_scan #(.N(N), .DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .En    (En),
        .Mode  (Mode),
        .Load  (Load),
        .i     (i),
        .o     (o),
        .code  (code),
        .tick  (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, act, $time);
        end
    endtask

    // Drive one cycle of inputs at the negedge. Then queue the outputs that
    // are expected after the following rising edge.
    task automatic step(input logic en, input logic mode, input logic load,
                        input logic [1:0] iv, input logic [1:0] ecode, input logic etick);
        exp_t e;
        @(negedge clk);
        En   = en;
        Mode = mode;
        Load = load;
        i    = iv;
        e.code = ecode;
        e.tick = etick;
        e.o    = en ? (4'b0001 << ecode) : 4'b0000;
        exp_q.push_back(e);
    endtask

    // Monitor: just after every rising edge, check the one-hot invariant.
    // If an expectation is queued, also compare the outputs against it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            chk("onehot_count_le1", 32'($countones(o) > 1), 32'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("code", 32'(code), 32'(e.code));
                chk("o",    32'(o),    32'(e.o));
                chk("tick", 32'(tick), 32'(e.tick));
            end
        end
    end

    // Watchdog: make sure the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        En    = 1'b0;
        Mode  = 1'b0;
        Load  = 1'b0;
        i     = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset_code", 32'(code), 32'd0);
        chk("reset_o",    32'(o),    32'd0);
        chk("reset_tick", 32'(tick), 32'd0);
        rst_n = 1'b1;

        // Direct mode: load 2. The o check happens just before the load edge.
        step(1, 0, 1, 2'd2, 2'd2, 0);
        #1;
        chk("o_before_load", 32'(o), 32'd0);
        step(1, 0, 0, 2'd0, 2'd2, 0);
        step(1, 0, 0, 2'd3, 2'd2, 0);   // i ignored without Load
        step(0, 0, 1, 2'd1, 2'd1, 0);   // load works with En=0, o stays 0
        step(1, 0, 0, 2'd0, 2'd1, 0);

        // Scan and wrap, starting from reset. Edge 0 is the Mode switch edge.
        @(negedge clk);
        rst_n = 1'b0;
        En    = 1'b0;
        Mode  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e <= 16; e++)
            step(1, 1, 0, 2'd0, 2'((e / 4) % 4), (e > 0) && (e % 4 == 0));

        // Enable gating: drop En for 3 cycles with the prescaler at 2.
        step(1, 1, 0, 2'd0, 2'd0, 0);   // e17 prescaler 1
        step(1, 1, 0, 2'd0, 2'd0, 0);   // e18 prescaler 2
        step(0, 1, 0, 2'd0, 2'd0, 0);   // e19..e21 frozen, o=0
        step(0, 1, 0, 2'd0, 2'd0, 0);
        step(0, 1, 0, 2'd0, 2'd0, 0);
        step(1, 1, 0, 2'd0, 2'd0, 0);   // e22 prescaler 3
        step(1, 1, 0, 2'd0, 2'd1, 1);   // e23 advance, 3 edges late
        step(1, 1, 0, 2'd0, 2'd1, 0);   // e24 prescaler 1

        // Load collides with a would-be advance.
        step(1, 1, 0, 2'd0, 2'd1, 0);   // e25 prescaler 2
        step(1, 1, 0, 2'd0, 2'd1, 0);   // e26 prescaler 3
        step(1, 1, 1, 2'd3, 2'd3, 0);   // e27 load wins, no tick
        step(1, 1, 0, 2'd0, 2'd3, 0);
        step(1, 1, 0, 2'd0, 2'd3, 0);
        step(1, 1, 0, 2'd0, 2'd3, 0);
        step(1, 1, 0, 2'd0, 2'd0, 1);   // e31 wraps 3 -> 0, 4 edges after load

        // Mode switch: prescaler at 2, drop to direct, then back to scan.
        step(1, 1, 0, 2'd0, 2'd0, 0);   // e32 prescaler 1
        step(1, 1, 0, 2'd0, 2'd0, 0);   // e33 prescaler 2
        step(1, 0, 0, 2'd0, 2'd0, 0);   // e34 direct, hold
        step(1, 0, 0, 2'd0, 2'd0, 0);   // e35
        step(1, 1, 0, 2'd0, 2'd0, 0);   // e36 switch 0->1, prescaler cleared
        step(1, 1, 0, 2'd0, 2'd0, 0);
        step(1, 1, 0, 2'd0, 2'd0, 0);
        step(1, 1, 0, 2'd0, 2'd0, 0);
        step(1, 1, 0, 2'd0, 2'd1, 1);   // e40 advance, 4 edges after switch

        // Async reset mid-scan, while tick is high.
        step(1, 1, 0, 2'd0, 2'd1, 0);
        step(1, 1, 0, 2'd0, 2'd1, 0);
        step(1, 1, 0, 2'd0, 2'd1, 0);
        step(1, 1, 0, 2'd0, 2'd2, 1);   // e44 advance
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        En    = 1'b0;
        Mode  = 1'b0;
        #1;
        chk("async_code", 32'(code), 32'd0);
        chk("async_o",    32'(o),    32'd0);
        chk("async_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // After reset, there is no tick until a full prescale count.
        for (int e = 0; e <= 5; e++)
            step(1, 1, 0, 2'd0, 2'((e / 4) % 4), (e > 0) && (e % 4 == 0));

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
